// File: rtl/ser_tx_pkg.sv
// ser_tx_pkg: shared constants and FSM state encoding for the serial transmitter
package ser_tx_pkg;
  localparam int DATA_W = 8;
  localparam int FRAME_BITS = 10;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;
endpackage

// File: rtl/ser_tx_8bit_if.sv
// ser_tx_8bit_if: byte handshake (valid/d/ready) plus serial outputs (tx/busy/done); master drives, slave transmits
interface ser_tx_8bit_if;
  logic valid;
  logic [ser_tx_pkg::DATA_W-1:0] d;
  logic ready;
  logic tx;
  logic busy;
  logic done;
  modport master (output valid, d, input ready, tx, busy, done);
  modport slave (input valid, d, output ready, tx, busy, done);
endinterface

// File: rtl/tx_baud_cnt.sv
// tx_baud_cnt: bit-period counter (clk, reset active-low async, clear holds at 0, bit_tick on last cycle of a bit)
module tx_baud_cnt #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_tick
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  logic [CW-1:0] cnt;
  assign bit_tick = !clear && cnt == CW'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else cnt <= (clear || bit_tick) ? '0 : cnt + CW'(1);
endmodule

// File: rtl/ser_tx_8bit.sv
// ser_tx_8bit: UART-style 8N1 transmitter (clk, reset active-low async, bus: valid/d in, ready/tx/busy/done out)
module ser_tx_8bit
  import ser_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input logic clk,
  input logic reset,
  ser_tx_8bit_if.slave bus
);
  state_t state, state_n;
  logic [DATA_W-1:0] sr, sr_n;
  logic [2:0] idx, idx_n;
  logic tick, tx_n, ready_n, busy_n, done_n;
  tx_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk(clk),
    .reset(reset),
    .clear(state == IDLE),
    .bit_tick(tick)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      sr <= '0;
      idx <= '0;
      bus.tx <= 1'b1;
      bus.ready <= 1'b1;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      state <= state_n;
      sr <= sr_n;
      idx <= idx_n;
      bus.tx <= tx_n;
      bus.ready <= ready_n;
      bus.busy <= busy_n;
      bus.done <= done_n;
    end
  always_comb begin
    state_n = state;
    sr_n = sr;
    idx_n = idx;
    case (state)
      IDLE: if (bus.valid) begin
        state_n = START;
        sr_n = bus.d;
      end
      START: if (tick) begin
        state_n = DATA;
        idx_n = '0;
      end
      DATA: if (tick) begin
        sr_n = sr >> 1;
        idx_n = idx + 3'd1;
        state_n = idx == 3'd7 ? STOP : DATA;
      end
      STOP: if (tick) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? sr_n[0] : 1'b1;
    ready_n = state_n == IDLE;
    busy_n = state_n != IDLE;
    done_n = state == STOP && state_n == IDLE;
  end
endmodule
